// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Purpose  : Shared types and helpers for the multicycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EVAL   = 4'd3,
        ST_REGRD  = 4'd4,
        ST_EXEC   = 4'd5,
        ST_MEM    = 4'd6,
        ST_WB     = 4'd7,
        ST_PCUPD  = 4'd8,
        ST_HALT   = 4'd9,
        ST_FAULT  = 4'd10
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_ALU    = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_class_t;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int timeout_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic instr_class_t encode_class(input logic alu,
                                                  input logic mem,
                                                  input logic branch);
        if (alu)
            return CLS_ALU;
        else if (mem)
            return CLS_MEM;
        else if (branch)
            return CLS_BRANCH;
        else
            return CLS_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Purpose  : Ready-handshake wait counter with bounded timeout.
// Revision : 1.0 - initial release
// ============================================================================
module seq_wait_timer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_req,
    input  logic ready,
    output logic expired
);

    localparam int               CNT_W = timeout_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_not_ready;

    assign w_not_ready = wait_req && !ready;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (w_not_ready && (cnt_q != LIMIT))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Asserted on the not-ready cycle that brings the count up to TIMEOUT.
    assign expired = w_not_ready && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Multi-cycle phase sequencer with program counter and ready
//            handshakes. Optional SEQ_PERF_CNT_EN adds cycle/retired counters.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            rom_ready,
    input  logic            ram_ready,
    input  logic            dec_done,
    input  logic            dec_alu,
    input  logic            dec_mem,
    input  logic            dec_branch,
    input  logic            dec_setcond,
    input  logic            cond_pass,
    input  logic [PC_W-1:0] branch_target,
    output logic            en_fetch,
    output logic            en_decode,
    output logic            en_eval,
    output logic            en_regrd,
    output logic            en_exec,
    output logic            en_mem,
    output logic            en_wb,
    output logic            mem_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     retired_cnt,
`endif
    output logic            fault
);

    seq_state_t   state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    instr_class_t class_q, class_d;
    logic         nowb_q, nowb_d;
    logic         cond_q, cond_d;

    logic w_start_ok;
    logic w_in_wait;
    logic w_ready;
    logic w_expired;

    assign w_start_ok = start && !busy;
    assign w_in_wait  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign w_ready    = (state_q == ST_FETCH) ? rom_ready : ram_ready;

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!w_in_wait),
        .wait_req (w_in_wait),
        .ready    (w_ready),
        .expired  (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (w_start_ok)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (rom_ready)
                    state_d = ST_DECODE;
                else if (w_expired)
                    state_d = ST_FAULT;
            end
            ST_DECODE: state_d = dec_done ? ST_HALT : ST_EVAL;
            ST_EVAL:   state_d = cond_pass ? ST_REGRD : ST_PCUPD;
            ST_REGRD: begin
                case (class_q)
                    CLS_ALU: state_d = ST_EXEC;
                    CLS_MEM: state_d = ST_MEM;
                    default: state_d = ST_PCUPD;
                endcase
            end
            ST_EXEC: state_d = nowb_q ? ST_PCUPD : ST_WB;
            ST_MEM: begin
                if (ram_ready)
                    state_d = nowb_q ? ST_PCUPD : ST_WB;
                else if (w_expired)
                    state_d = ST_FAULT;
            end
            ST_WB:    state_d = ST_PCUPD;
            ST_PCUPD: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Per-instruction context and program counter. For a memory op the
    // "no register write" flag distinguishes a store from a load.
    always_comb begin
        pc_d    = pc_q;
        class_d = class_q;
        nowb_d  = nowb_q;
        cond_d  = cond_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (w_start_ok)
                    pc_d = RESET_PC;
            end
            ST_DECODE: begin
                class_d = encode_class(dec_alu, dec_mem, dec_branch);
                nowb_d  = dec_setcond;
            end
            ST_EVAL: cond_d = cond_pass;
            ST_PCUPD: begin
                if ((class_q == CLS_BRANCH) && cond_q)
                    pc_d = branch_target;
                else
                    pc_d = pc_q + PC_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            class_q <= CLS_NONE;
            nowb_q  <= 1'b0;
            cond_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            class_q <= class_d;
            nowb_q  <= nowb_d;
            cond_q  <= cond_d;
        end
    end

    // Output decode of the registered state
    always_comb begin
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        en_eval   = 1'b0;
        en_regrd  = 1'b0;
        en_exec   = 1'b0;
        en_mem    = 1'b0;
        en_wb     = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fault     = 1'b0;
        case (state_q)
            ST_FETCH:  begin en_fetch  = 1'b1; busy = 1'b1; end
            ST_DECODE: begin en_decode = 1'b1; busy = 1'b1; end
            ST_EVAL:   begin en_eval   = 1'b1; busy = 1'b1; end
            ST_REGRD:  begin en_regrd  = 1'b1; busy = 1'b1; end
            ST_EXEC:   begin en_exec   = 1'b1; busy = 1'b1; end
            ST_MEM:    begin en_mem    = 1'b1; mem_we = nowb_q; busy = 1'b1; end
            ST_WB:     begin en_wb     = 1'b1; busy = 1'b1; end
            ST_PCUPD:  busy  = 1'b1;
            ST_HALT:   done  = 1'b1;
            ST_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    assign pc = pc_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (w_start_ok) begin
            cycle_cnt_d   = '0;
            retired_cnt_d = '0;
        end else begin
            if (busy && (cycle_cnt_q != '1))
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            if ((state_q == ST_PCUPD) && (retired_cnt_q != '1))
                retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule
`default_nettype wire
